// File: rtl/if_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : if_stage_if
// Description : Signal bundle between the instruction-fetch stage and its
//               neighbours. The bundle carries the hazard and redirect
//               controls from decode and CP0, the instruction-memory
//               address/data pair, and the IF/ID pipeline register outputs.
//               master : the fetch stage (drives IMAddr and the IF/ID outputs)
//               slave  : the surrounding pipeline and memory
// Revision    : 1.0  initial release
// ============================================================================
interface if_stage_if;
    // Controls and targets from decode, hazard unit and CP0
    logic        Stall;
    logic        branch;
    logic        jump;
    logic [31:0] branch_addr32;
    logic [31:0] jump_addr32;
    logic        IsBJ_ID;
    logic        ErrSignal;
    logic        eretEn;
    logic [31:0] EPCData;
    // Instruction memory
    logic [31:0] IMData;
    logic [31:0] IMAddr;
    // IF/ID pipeline register
    logic [31:0] Instr_IF_to_ID;
    logic [31:0] PC_IF_to_ID;
    logic [31:0] PC_4_IF_to_ID;
    logic [4:0]  ErrStat_IF_to_ID;
    logic        Err_IF_to_ID;
    logic        BD_IF_to_ID;

    modport master (
        input  Stall, branch, jump, branch_addr32, jump_addr32, IsBJ_ID,
               ErrSignal, eretEn, EPCData, IMData,
        output IMAddr, Instr_IF_to_ID, PC_IF_to_ID, PC_4_IF_to_ID,
               ErrStat_IF_to_ID, Err_IF_to_ID, BD_IF_to_ID
    );

    modport slave (
        output Stall, branch, jump, branch_addr32, jump_addr32, IsBJ_ID,
               ErrSignal, eretEn, EPCData, IMData,
        input  IMAddr, Instr_IF_to_ID, PC_IF_to_ID, PC_4_IF_to_ID,
               ErrStat_IF_to_ID, Err_IF_to_ID, BD_IF_to_ID
    );
endinterface
`default_nettype wire

// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
// Module      : if_stage
// Description : Instruction-fetch stage of the 5-stage MIPS pipeline.
//               Holds the PC, selects the next PC (reset, exception entry,
//               eret return, stall hold, branch, jump, sequential), drives
//               the instruction-memory address, flags fetch address errors
//               (AdEL) and loads the IF/ID pipeline register.
// Ports       : clk    - clock
//               reset  - synchronous active-high reset
//               bus    - if_stage_if.master: redirect/stall controls in,
//                        IMData in, IMAddr and IF/ID register contents out
// Revision    : 1.0  initial release
// ============================================================================
module if_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
    parameter logic [31:0] IM_BASE    = 32'h0000_3000,
    parameter logic [31:0] IM_END     = 32'h0000_6FFC,
    parameter logic [4:0]  EXC_ADEL   = 5'd4,
    parameter logic [4:0]  EXC_NONE   = 5'd31
) (
    input  wire logic     clk,
    input  wire logic     reset,
    if_stage_if.master    bus
);

    logic [31:0] r_pc;
    logic [31:0] w_pc_plus4;
    logic        w_adel;
    logic [31:0] w_fetch_instr;

    logic [31:0] r_instr;
    logic [31:0] r_pc_id;
    logic [31:0] r_pc4_id;
    logic [4:0]  r_errstat;
    logic        r_err;
    logic        r_bd;

    assign w_pc_plus4 = r_pc + 32'd4;

    // An illegal fetch address turns the slot into a nop carrying an AdEL
    // status; the memory word at that address is never consumed.
    assign w_adel        = (r_pc[1:0] != 2'b00) || (r_pc < IM_BASE) || (r_pc > IM_END);
    assign w_fetch_instr = w_adel ? 32'h0000_0000 : bus.IMData;

    // PC register. Exception entry and eret outrank the stall so a flush is
    // never lost behind a hazard; a stalled branch is re-presented by decode.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc <= RESET_PC;
        end else if (bus.ErrSignal) begin
            r_pc <= HANDLER_PC;
        end else if (bus.eretEn) begin
            r_pc <= bus.EPCData;
        end else if (bus.Stall) begin
            r_pc <= r_pc;
        end else if (bus.branch) begin
            r_pc <= bus.branch_addr32;
        end else if (bus.jump) begin
            r_pc <= bus.jump_addr32;
        end else begin
            r_pc <= w_pc_plus4;
        end
    end

    // IF/ID register. On a redirect the slot being fetched is the delay slot
    // and is captured normally; only exception entry and eret insert a bubble,
    // and that bubble carries the new PC so downstream sees a coherent PC.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_instr   <= 32'h0000_0000;
            r_pc_id   <= RESET_PC;
            r_pc4_id  <= RESET_PC + 32'd4;
            r_errstat <= EXC_NONE;
            r_err     <= 1'b0;
            r_bd      <= 1'b0;
        end else if (bus.ErrSignal) begin
            r_instr   <= 32'h0000_0000;
            r_pc_id   <= HANDLER_PC;
            r_pc4_id  <= HANDLER_PC + 32'd4;
            r_errstat <= EXC_NONE;
            r_err     <= 1'b0;
            r_bd      <= 1'b0;
        end else if (bus.eretEn) begin
            r_instr   <= 32'h0000_0000;
            r_pc_id   <= bus.EPCData;
            r_pc4_id  <= bus.EPCData + 32'd4;
            r_errstat <= EXC_NONE;
            r_err     <= 1'b0;
            r_bd      <= 1'b0;
        end else if (!bus.Stall) begin
            r_instr   <= w_fetch_instr;
            r_pc_id   <= r_pc;
            r_pc4_id  <= w_pc_plus4;
            r_errstat <= w_adel ? EXC_ADEL : EXC_NONE;
            r_err     <= w_adel;
            // The instruction in decode being a branch/jump makes the one
            // being fetched now its delay slot.
            r_bd      <= bus.IsBJ_ID;
        end
    end

    assign bus.IMAddr           = r_pc;
    assign bus.Instr_IF_to_ID   = r_instr;
    assign bus.PC_IF_to_ID      = r_pc_id;
    assign bus.PC_4_IF_to_ID    = r_pc4_id;
    assign bus.ErrStat_IF_to_ID = r_errstat;
    assign bus.Err_IF_to_ID     = r_err;
    assign bus.BD_IF_to_ID      = r_bd;

endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_stage
// Description : Self-checking bench for if_stage. Directed scenarios cover
//               sequential fetch, branch delay slot, stall, illegal targets,
//               IM_END boundary, exception entry, eret and reset; a random
//               phase follows. Expected values come from a fetch-stage model
//               built on the pipeline's architectural rules.
// Revision    : 1.0  initial release
// ============================================================================
module tb_if_stage;

    localparam logic [31:0] C_RESET_PC   = 32'h0000_3000;
    localparam logic [31:0] C_HANDLER_PC = 32'h0000_4180;
    localparam logic [31:0] C_IM_BASE    = 32'h0000_3000;
    localparam logic [31:0] C_IM_END     = 32'h0000_6FFC;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    if_stage_if bus ();

    if_stage dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction ROM: a distinct word for every address
    function automatic logic [31:0] imem(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_2468;
    endfunction

    assign bus.IMData = imem(bus.IMAddr);

    // ---------------- reference model ----------------
    // Architectural view: the address being fetched and the slot handed to
    // decode (instr, pc, pc+4, error code, delay-slot flag).
    logic [31:0] m_fetch;
    logic [31:0] m_instr, m_pc, m_pc4;
    logic [4:0]  m_code;
    logic        m_err, m_bd;

    function automatic bit legal(input logic [31:0] a);
        return (a % 4 == 0) && a >= C_IM_BASE && a <= C_IM_END;
    endfunction

    task automatic bubble(input logic [31:0] new_pc);
        m_instr = 0; m_pc = new_pc; m_pc4 = new_pc + 4;
        m_code = 31; m_err = 0; m_bd = 0;
        m_fetch = new_pc;
    endtask

    task automatic model_clock();
        if (rst)                bubble(C_RESET_PC);
        else if (bus.ErrSignal) bubble(C_HANDLER_PC);
        else if (bus.eretEn)    bubble(bus.EPCData);
        else if (!bus.Stall) begin
            // hand the current fetch to decode
            m_pc    = m_fetch;
            m_pc4   = m_fetch + 4;
            m_instr = legal(m_fetch) ? imem(m_fetch) : 32'h0;
            m_err   = !legal(m_fetch);
            m_code  = legal(m_fetch) ? 5'd31 : 5'd4;
            m_bd    = bus.IsBJ_ID;
            if (bus.branch)    m_fetch = bus.branch_addr32;
            else if (bus.jump) m_fetch = bus.jump_addr32;
            else               m_fetch = m_fetch + 4;
        end
    endtask

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        check_eq("IMAddr",  bus.IMAddr,                   m_fetch);
        check_eq("Instr",   bus.Instr_IF_to_ID,           m_instr);
        check_eq("PC",      bus.PC_IF_to_ID,              m_pc);
        check_eq("PC_4",    bus.PC_4_IF_to_ID,            m_pc4);
        check_eq("ErrStat", {27'd0, bus.ErrStat_IF_to_ID}, {27'd0, m_code});
        check_eq("Err",     {31'd0, bus.Err_IF_to_ID},     {31'd0, m_err});
        check_eq("BD",      {31'd0, bus.BD_IF_to_ID},      {31'd0, m_bd});
    endtask

    // Advance one clock: model consumes the inputs present now, DUT is
    // sampled 1 time unit after the edge.
    task automatic cycle();
        model_clock();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic idle_inputs();
        rst = 0;
        bus.Stall = 0; bus.branch = 0; bus.jump = 0; bus.IsBJ_ID = 0;
        bus.ErrSignal = 0; bus.eretEn = 0;
        bus.branch_addr32 = 0; bus.jump_addr32 = 0; bus.EPCData = 0;
    endtask

    function automatic logic [31:0] pick_addr();
        case ($urandom % 8)
            0:       return $urandom;
            1:       return C_IM_BASE + ($urandom_range(0, 15) * 4) + $urandom_range(1, 3);
            2:       return C_IM_END - $urandom_range(0, 2) * 4;
            default: return C_IM_BASE + $urandom_range(0, (C_IM_END - C_IM_BASE) / 4) * 4;
        endcase
    endfunction

    initial begin
        total = 0;
        bad   = 0;
        idle_inputs();
        m_fetch = 'x;

        // Reset for 2 cycles
        rst = 1;
        cycle();
        cycle();
        check_eq("rst_imaddr", bus.IMAddr, 32'h3000);
        check_eq("rst_errstat", {27'd0, bus.ErrStat_IF_to_ID}, 32'd31);
        rst = 0;

        // Sequential fetch
        cycle();
        check_eq("seq_imaddr", bus.IMAddr, 32'h3004);
        check_eq("seq_pc", bus.PC_IF_to_ID, 32'h3000);
        check_eq("seq_instr", bus.Instr_IF_to_ID, imem(32'h3000));
        cycle();
        cycle();
        check_eq("seq_imaddr2", bus.IMAddr, 32'h300C);

        // Branch at 0x3010 with delay-slot tagging
        begin
            int n = 0;
            while (bus.IMAddr != 32'h3010 && n < 20) begin cycle(); n++; end
            check_eq("reach_3010", bus.IMAddr, 32'h3010);
        end
        bus.branch = 1; bus.branch_addr32 = 32'h3100; bus.IsBJ_ID = 1;
        cycle();
        check_eq("br_pc", bus.PC_IF_to_ID, 32'h3010);
        check_eq("br_bd", {31'd0, bus.BD_IF_to_ID}, 32'd1);
        check_eq("br_target", bus.IMAddr, 32'h3100);
        idle_inputs();
        cycle();
        check_eq("br_target_pc", bus.PC_IF_to_ID, 32'h3100);
        check_eq("br_target_bd", {31'd0, bus.BD_IF_to_ID}, 32'd0);

        // Stall for 3 cycles at 0x3020
        bus.jump = 1; bus.jump_addr32 = 32'h3020;
        cycle();
        idle_inputs();
        bus.Stall = 1;
        repeat (3) cycle();
        check_eq("stall_imaddr", bus.IMAddr, 32'h3020);
        bus.Stall = 0;
        cycle();
        check_eq("stall_resume", bus.IMAddr, 32'h3024);
        check_eq("stall_resume_pc", bus.PC_IF_to_ID, 32'h3020);

        // Jump to misaligned 0x3002, then to 0x7000 beyond IM_END
        bus.jump = 1; bus.jump_addr32 = 32'h3002;
        cycle();
        idle_inputs();
        cycle();
        check_eq("adel1_pc", bus.PC_IF_to_ID, 32'h3002);
        check_eq("adel1_instr", bus.Instr_IF_to_ID, 32'h0);
        check_eq("adel1_err", {31'd0, bus.Err_IF_to_ID}, 32'd1);
        check_eq("adel1_code", {27'd0, bus.ErrStat_IF_to_ID}, 32'd4);
        bus.jump = 1; bus.jump_addr32 = 32'h7000;
        cycle();
        idle_inputs();
        cycle();
        check_eq("adel2_pc", bus.PC_IF_to_ID, 32'h7000);
        check_eq("adel2_code", {27'd0, bus.ErrStat_IF_to_ID}, 32'd4);

        // Fall off IM_END sequentially
        bus.jump = 1; bus.jump_addr32 = C_IM_END;
        cycle();
        idle_inputs();
        cycle();
        check_eq("end_ok_err", {31'd0, bus.Err_IF_to_ID}, 32'd0);
        cycle();
        check_eq("end_over_pc", bus.PC_IF_to_ID, 32'h7000);
        check_eq("end_over_err", {31'd0, bus.Err_IF_to_ID}, 32'd1);

        // Exception entry beats stall and branch
        bus.ErrSignal = 1; bus.Stall = 1; bus.branch = 1; bus.branch_addr32 = 32'h3200;
        bus.IsBJ_ID = 1;
        cycle();
        check_eq("exc_pc", bus.PC_IF_to_ID, 32'h4180);
        check_eq("exc_imaddr", bus.IMAddr, 32'h4180);
        check_eq("exc_bd", {31'd0, bus.BD_IF_to_ID}, 32'd0);
        idle_inputs();

        // eret to 0x3040, then reset mid-sequence
        bus.eretEn = 1; bus.EPCData = 32'h3040; bus.Stall = 1;
        cycle();
        check_eq("eret_pc", bus.PC_IF_to_ID, 32'h3040);
        check_eq("eret_imaddr", bus.IMAddr, 32'h3040);
        idle_inputs();
        cycle();
        bus.jump = 1; bus.jump_addr32 = 32'h5000; rst = 1;
        cycle();
        check_eq("rst_mid_imaddr", bus.IMAddr, 32'h3000);
        idle_inputs();
        cycle();

        // Random phase
        for (int i = 0; i < 600; i++) begin
            rst           = ($urandom % 40) == 0;
            bus.ErrSignal = ($urandom % 16) == 0;
            bus.eretEn    = ($urandom % 16) == 0;
            bus.Stall     = ($urandom % 4) == 0;
            bus.branch    = ($urandom % 5) == 0;
            bus.jump      = !bus.branch && (($urandom % 5) == 0);
            bus.IsBJ_ID   = $urandom % 2;
            bus.branch_addr32 = pick_addr();
            bus.jump_addr32   = pick_addr();
            bus.EPCData       = pick_addr();
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
